// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit_pkg
//
// Shared ISA-side types for the hart load/store path:
//   - XLEN                 : data/address width (RV32I)
//   - write_width_t        : byte/halfword/word write width toward memory
//   - mem_control_t        : registered control bundle driven toward memory
//   - lsu_funct3_t         : RV32I load/store funct3 encodings
//   - lsu_state_t          : load_store_unit sequencer states
//   - load_extend()        : sign/zero extension of a load result
//   - store_width()        : funct3 -> write width for stores
//   - lsu_funct3_legal()   : funct3 legality for loads and stores
//   - lsu_misaligned()     : natural-alignment test for an access
//
// Build option:
//   LSU_MISALIGN_TRAP_EN   : when defined, misaligned halfword/word accesses
//                            are treated as illegal requests (fault, no
//                            memory access). When undefined they go to memory
//                            as-is and memory handles them byte-wise.
// -----------------------------------------------------------------------------
package load_store_unit_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    write_byte     = 2'd0,
    write_halfword = 2'd1,
    write_word     = 2'd2
  } write_width_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            wenable;
    logic [XLEN-1:0] wdata;
    write_width_t    wwidth;
  } mem_control_t;

  // Loads use all five codes; stores use only the first three (SB/SH/SW).
  typedef enum logic [2:0] {
    F3_BYTE   = 3'b000,
    F3_HALF   = 3'b001,
    F3_WORD   = 3'b010,
    F3_BYTE_U = 3'b100,
    F3_HALF_U = 3'b101
  } lsu_funct3_t;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_STORE = 2'd1,
    LSU_LOAD  = 2'd2,
    LSU_RESP  = 2'd3
  } lsu_state_t;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit LSU_MISALIGN_TRAP = 1'b1;
`else
  localparam bit LSU_MISALIGN_TRAP = 1'b0;
`endif

  // Extend the low bytes of a memory word according to the load funct3.
  // Unknown codes pass the word through; they never reach here because
  // illegal loads are diverted before any memory access.
  function automatic logic [XLEN-1:0] load_extend(input logic [2:0]      funct3,
                                                  input logic [XLEN-1:0] word);
    logic [XLEN-1:0] ext;
    ext = word;
    case (funct3)
      F3_BYTE:   ext = {{(XLEN-8){word[7]}}, word[7:0]};
      F3_BYTE_U: ext = {{(XLEN-8){1'b0}}, word[7:0]};
      F3_HALF:   ext = {{(XLEN-16){word[15]}}, word[15:0]};
      F3_HALF_U: ext = {{(XLEN-16){1'b0}}, word[15:0]};
      F3_WORD:   ext = word;
      default:   ext = word;
    endcase
    return ext;
  endfunction

  function automatic write_width_t store_width(input logic [2:0] funct3);
    write_width_t w;
    w = write_word;
    case (funct3)
      F3_BYTE: w = write_byte;
      F3_HALF: w = write_halfword;
      F3_WORD: w = write_word;
      default: w = write_word;
    endcase
    return w;
  endfunction

  function automatic logic lsu_funct3_legal(input logic       is_store,
                                            input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    if (is_store) begin
      ok = (funct3 == F3_BYTE) || (funct3 == F3_HALF) || (funct3 == F3_WORD);
    end else begin
      ok = (funct3 == F3_BYTE)   || (funct3 == F3_HALF) || (funct3 == F3_WORD) ||
           (funct3 == F3_BYTE_U) || (funct3 == F3_HALF_U);
    end
    return ok;
  endfunction

  // funct3[1:0] encodes the access size for every legal code:
  // 00 byte, 01 halfword, 10 word.
  function automatic logic lsu_misaligned(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3[1:0])
      2'b01:   mis = addr_lo[0];
      2'b10:   mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_load_format.sv
// -----------------------------------------------------------------------------
// lsu_load_format
//
// Combinational load-data extender, sitting on the mem_rdata sample path of
// load_store_unit. Kept as its own module so it can be exercised standalone.
//
// Ports:
//   funct3  in   3     load funct3 (LB/LH/LW/LBU/LHU)
//   word    in   XLEN  raw memory read data, byte at addr in [7:0]
//   rdata   out  XLEN  sign- or zero-extended result
// -----------------------------------------------------------------------------
module lsu_load_format
  import load_store_unit_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] rdata
);

  always_comb begin
    rdata = load_extend(funct3, word);
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Hart-side sequencer between execute and memory. Takes one RV32I load or
// store per transaction, drives a registered mem_control_t toward memory,
// waits out the memory read latency, extends load data and returns a single
// response. Illegal requests return immediately with resp_fault=1 and never
// touch memory.
//
// Parameters:
//   READ_LATENCY  cycles from a stable mem_ctrl.addr until mem_rdata is valid
//                 (0 = combinational, legal range 0-7)
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  misaligned halfword/word requests take the fault path
//
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   req_valid/ready    request handshake (ready only in IDLE)
//   req_store          1 = store, 0 = load
//   req_funct3         RV32I funct3
//   req_addr           byte address, passed through unchanged
//   req_wdata          store data, right-aligned
//   resp_valid/ready   response handshake
//   resp_rdata         extended load data; 0 for stores and faults
//   resp_fault         request was illegal
//   mem_ctrl           registered addr/wenable/wdata/wwidth toward memory
//   mem_rdata          memory read data
//   state_dbg          current sequencer state (lsu_state_t encoding)
//
// Handshake: a transfer happens on a clock edge where valid && ready. A
// request is accepted in IDLE at the first edge with req_valid=1; req_valid
// seen in any other state is ignored (nothing is queued). Once resp_valid is
// raised, resp_valid, resp_rdata and resp_fault stay put until the edge where
// resp_ready=1; resp_valid does not depend on resp_ready.
// -----------------------------------------------------------------------------
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int READ_LATENCY = 1
)
(
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_rdata,
  output logic             resp_fault,
  output mem_control_t     mem_ctrl,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic [1:0]       state_dbg
);

  // Countdown start value: LOAD lasts READ_LATENCY+1 cycles, the last one
  // being the cycle in which the counter reads zero.
  localparam logic [2:0] LOAD_CNT_INIT = 3'(READ_LATENCY);

  lsu_state_t      state;
  lsu_state_t      state_next;
  logic [2:0]      load_cnt;
  logic [2:0]      funct3_q;
  logic            req_legal;
  logic            accept;
  logic            load_done;
  logic [XLEN-1:0] load_fmt_data;

  // Legality is judged on the live request so the IDLE decision and the
  // fault flag agree on the accepting edge.
  always_comb begin
    req_legal = lsu_funct3_legal(req_store, req_funct3) &&
                !(LSU_MISALIGN_TRAP && lsu_misaligned(req_funct3, req_addr[1:0]));
  end

  assign accept    = (state == LSU_IDLE) && req_valid;
  assign load_done = (state == LSU_LOAD) && (load_cnt == 3'd0);
  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= LSU_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      LSU_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!req_legal) begin
            state_next = LSU_RESP;
          end else if (req_store) begin
            state_next = LSU_STORE;
          end else begin
            state_next = LSU_LOAD;
          end
        end
      end
      LSU_STORE: begin
        state_next = LSU_RESP;
      end
      LSU_LOAD: begin
        if (load_cnt == 3'd0) begin
          state_next = LSU_RESP;
        end
      end
      LSU_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = LSU_IDLE;
        end
      end
      default: begin
        state_next = LSU_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load data extension on the sample path
  // ---------------------------------------------------------------------------
  lsu_load_format u_load_format (
    .funct3 (funct3_q),
    .word   (mem_rdata),
    .rdata  (load_fmt_data)
  );

  // ---------------------------------------------------------------------------
  // Datapath: memory control, load counter and response registers.
  // wenable defaults low every cycle, so it is high for exactly the one STORE
  // cycle following acceptance. addr/wdata/wwidth only change on acceptance of
  // a legal request and otherwise hold their last values.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_ctrl.addr    <= '0;
      mem_ctrl.wenable <= 1'b0;
      mem_ctrl.wdata   <= '0;
      mem_ctrl.wwidth  <= write_word;
      load_cnt         <= 3'd0;
      funct3_q         <= 3'd0;
      resp_rdata       <= '0;
      resp_fault       <= 1'b0;
    end else begin
      mem_ctrl.wenable <= 1'b0;

      if (accept) begin
        funct3_q   <= req_funct3;
        resp_rdata <= '0;
        resp_fault <= !req_legal;
        if (req_legal) begin
          mem_ctrl.addr <= req_addr;
          load_cnt      <= LOAD_CNT_INIT;
          if (req_store) begin
            mem_ctrl.wenable <= 1'b1;
            mem_ctrl.wdata   <= req_wdata;
            mem_ctrl.wwidth  <= store_width(req_funct3);
          end
        end
      end

      if (state == LSU_LOAD) begin
        if (load_done) begin
          resp_rdata <= load_fmt_data;
        end else begin
          load_cnt <= load_cnt - 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Drives load_store_unit against a byte-addressed memory model with a
// configurable read pipeline, and compares every response against a
// reference built from a separate byte array updated by request semantics.
// Honours LSU_MISALIGN_TRAP_EN for the misalignment cases.
// -----------------------------------------------------------------------------
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int RL        = 3;
  localparam int AW        = 13;
  localparam int MEM_BYTES = 1 << AW;
  localparam int RESP_WAIT = 20;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_store = 1'b0;
  logic [2:0]      req_funct3 = 3'd0;
  logic [XLEN-1:0] req_addr = '0;
  logic [XLEN-1:0] req_wdata = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_fault;
  mem_control_t    mem_ctrl;
  logic [XLEN-1:0] mem_rdata;
  logic [1:0]      state_dbg;

  always #5 clock = ~clock;

  load_store_unit #(.READ_LATENCY(RL)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_ctrl   (mem_ctrl),
    .mem_rdata  (mem_rdata),
    .state_dbg  (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Counters and scoreboard
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  int wen_count = 0;
  logic [32:0] exp_q[$];   // {fault, rdata}

  // ---------------------------------------------------------------------------
  // Memory model seen by the DUT: byte array, byte-wise writes, reads of the
  // address presented RL cycles earlier.
  // ---------------------------------------------------------------------------
  logic [7:0]      sim_mem [0:MEM_BYTES-1];
  logic [7:0]      ref_mem [0:MEM_BYTES-1];
  logic [XLEN-1:0] addr_hist [0:7];
  logic [XLEN-1:0] rd_addr;
  logic            mem_loaded = 1'b0;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37) ^ (i >> 5) ^ 8'h5A);
  endfunction

  function automatic int width_bytes(input write_width_t w);
    int n;
    n = 4;
    if (w == write_byte) n = 1;
    else if (w == write_halfword) n = 2;
    return n;
  endfunction

  always @(posedge clock) begin
    if (!mem_loaded) begin
      for (int i = 0; i < MEM_BYTES; i++) sim_mem[i] <= init_byte(i);
      mem_loaded <= 1'b1;
    end
    if (mem_ctrl.wenable) begin
      for (int k = 0; k < width_bytes(mem_ctrl.wwidth); k++)
        sim_mem[AW'(mem_ctrl.addr + XLEN'(k))] <= mem_ctrl.wdata[8*k +: 8];
    end
    for (int i = 7; i > 0; i--) addr_hist[i] <= addr_hist[i-1];
    addr_hist[0] <= mem_ctrl.addr;
  end

  always_comb begin
    rd_addr   = (RL == 0) ? mem_ctrl.addr : addr_hist[(RL == 0) ? 0 : RL - 1];
    mem_rdata = {sim_mem[AW'(rd_addr + 32'd3)], sim_mem[AW'(rd_addr + 32'd2)],
                 sim_mem[AW'(rd_addr + 32'd1)], sim_mem[AW'(rd_addr)]};
  end

  always @(negedge clock) begin
    if (mem_ctrl.wenable === 1'b1) wen_count++;
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int access_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit model_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit ok;
    bit mis;
    if (st) ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    mis = (a % access_bytes(f3)) != 0;
    return ok && !(TRAP && mis);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    longint v;
    int n;
    n = access_bytes(f3);
    v = 0;
    for (int k = 0; k < n; k++) v = v + (longint'(ref_mem[AW'(a + 32'(k))]) << (8 * k));
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < access_bytes(f3); k++) ref_mem[AW'(a + 32'(k))] = d[8*k +: 8];
  endtask

  // ---------------------------------------------------------------------------
  // Checker and drivers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input int hold, input bit noise);
    bit          legal;
    int          exp_lat;
    int          lat;
    int          wen0;
    bit          seen;
    logic [32:0] exp;
    write_width_t exp_w;

    legal = model_legal(st, f3, a);
    if (!legal) begin
      exp = {1'b1, 32'd0};
      exp_lat = 1;
    end else if (st) begin
      exp = {1'b0, 32'd0};
      exp_lat = 2;
      model_store(f3, a, d);
    end else begin
      exp = {1'b0, model_load(f3, a)};
      exp_lat = RL + 2;
    end
    exp_q.push_back(exp);
    exp_w = (f3 == 3'd0) ? write_byte : (f3 == 3'd1) ? write_halfword : write_word;

    @(negedge clock);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = d;
    wen0 = wen_count;
    @(posedge clock); #1;
    req_valid = 1'b0;

    if (legal && st) begin
      check("store_wenable", 32'(mem_ctrl.wenable), 32'd1);
      check("store_addr", mem_ctrl.addr, a);
      check("store_wdata", mem_ctrl.wdata, d);
      check("store_wwidth", 32'(mem_ctrl.wwidth), 32'(exp_w));
    end else if (legal) begin
      check("load_addr", mem_ctrl.addr, a);
    end

    lat = 1;
    seen = 1'b0;
    while (!seen && lat <= RESP_WAIT) begin
      if (resp_valid === 1'b1) seen = 1'b1;
      else begin
        @(posedge clock); #1;
        lat++;
      end
    end
    exp = exp_q.pop_front();
    check("resp_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("resp_latency", 32'(lat), 32'(exp_lat));
      check("resp_rdata", resp_rdata, exp[31:0]);
      check("resp_fault", 32'(resp_fault), 32'(exp[32]));
      for (int h = 0; h < hold; h++) begin
        if (noise) req_valid = 1'b1;
        @(posedge clock); #1;
        check("hold_valid", 32'(resp_valid), 32'd1);
        check("hold_rdata", resp_rdata, exp[31:0]);
        check("hold_req_ready", 32'(req_ready), 32'd0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(posedge clock); #1;
      resp_ready = 1'b0;
      check("release_valid", 32'(resp_valid), 32'd0);
      check("release_idle", 32'(req_ready), 32'd1);
    end
    check("wenable_cycles", 32'(wen_count - wen0), (legal && st) ? 32'd1 : 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Global time limit
  // ---------------------------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed and random sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit seen;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(i);

    // Reset values
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_fault", 32'(resp_fault), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_wenable", 32'(mem_ctrl.wenable), 32'd0);
    check("rst_addr", mem_ctrl.addr, 32'd0);
    check("rst_wdata", mem_ctrl.wdata, 32'd0);
    check("rst_wwidth", 32'(mem_ctrl.wwidth), 32'(write_word));
    check("rst_req_ready", 32'(req_ready), 32'd1);
    reset = 1'b0;

    // Word store, then byte/halfword loads of it
    run_req(1'b1, 3'b010, 32'h800, 32'h8765_4321, 0, 1'b0);
    run_req(1'b0, 3'b000, 32'h803, 32'd0, 0, 1'b0);
    check("lb_value", resp_rdata, 32'hFFFF_FF87);
    run_req(1'b0, 3'b100, 32'h803, 32'd0, 0, 1'b0);
    check("lbu_value", resp_rdata, 32'h0000_0087);
    run_req(1'b0, 3'b101, 32'h802, 32'd0, 0, 1'b0);
    check("lhu_value", resp_rdata, 32'h0000_8765);
    run_req(1'b0, 3'b001, 32'h800, 32'd0, 0, 1'b0);
    check("lh_value", resp_rdata, 32'h0000_4321);
    run_req(1'b0, 3'b010, 32'h800, 32'd0, 0, 1'b0);

    // Byte store writes only the low byte
    run_req(1'b1, 3'b000, 32'h1800, 32'hFFFF_FFA5, 0, 1'b0);
    check("sb_mem_byte0", 32'(sim_mem[13'h1800]), 32'h0000_00A5);
    check("sb_mem_byte1", 32'(sim_mem[13'h1801]), 32'(init_byte(32'h1801)));

    // Illegal requests
    run_req(1'b0, 3'b011, 32'h900, 32'd0, 0, 1'b0);
    run_req(1'b1, 3'b100, 32'h904, 32'hDEAD_BEEF, 0, 1'b0);
    run_req(1'b0, 3'b111, 32'h908, 32'd0, 0, 1'b0);

    // Response held for 5 cycles with req_valid noise
    run_req(1'b0, 3'b010, 32'h1800, 32'd0, 5, 1'b1);

    // Reset during the first LOAD cycle drops the transaction
    @(negedge clock);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400;
    @(posedge clock); #1;
    req_valid = 1'b0;
    check("mid_load_busy", 32'(req_ready), 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("mid_rst_idle", 32'(req_ready), 32'd1);
    check("mid_rst_valid", 32'(resp_valid), 32'd0);
    seen = 1'b0;
    repeat (RL + 4) begin
      @(posedge clock); #1;
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    check("mid_rst_no_resp", 32'(seen), 32'd0);

    // Misaligned word access
`ifdef LSU_MISALIGN_TRAP_EN
    run_req(1'b0, 3'b010, 32'h801, 32'd0, 0, 1'b0);
    check("lw_misaligned_fault", 32'(resp_fault), 32'd1);
`else
    run_req(1'b0, 3'b010, 32'h1001, 32'd0, 0, 1'b0);
    check("lw_misaligned_bytes", resp_rdata,
          {ref_mem[13'h1004], ref_mem[13'h1003], ref_mem[13'h1002], ref_mem[13'h1001]});
`endif

    // Random mix of loads and stores over a small address window so that
    // loads frequently hit earlier stores
    for (int n = 0; n < 60; n++) begin
      run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              32'($urandom_range(32'h1000, 32'h103F)), $urandom,
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
